// File: rtl/snake_pkg.sv
// Shared encodings for the snake game controller: FSM states, move directions,
// and the reversal test used to filter illegal turns.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    localparam logic [7:0] SCORE_MAX = 8'hFF;

    // Opposite directions share the axis bit and differ in the sense bit.
    function automatic logic is_reverse(input dir_e a, input dir_e b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_debounce.sv
// One button channel: 2-FF synchronizer, counting debouncer and a one-cycle
// pulse on each falling edge of the debounced level.
module snake_debounce #(
    parameter int   DEB_CYCLES = 16,
    parameter logic RST_VAL    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_fall
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], i_raw};
        level_d = level_q;
        cnt_d   = '0;
        // Any sample that agrees with the current level restarts the run.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) level_d = sync_q[1];
            else                              cnt_d   = cnt_q + 1'b1;
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {2{RST_VAL}};
            level_q <= RST_VAL;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;
    assign o_fall  = fall_q;
endmodule

// File: rtl/snake_ctrl.sv
// Snake game control FSM: debounced buttons, move tick generation,
// direction steering, scoring and game-over handling.
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int DEB_CYCLES = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] i_Push,
    input  logic       i_Pause,
    input  logic       i_Collide,
    input  logic       i_Eat,
    output logic       o_Step,
    output logic [1:0] o_Dir,
    output logic [1:0] o_State,
    output logic [7:0] o_Score
);
    localparam int             TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

    logic [3:0] push_level, push_fall;
    logic       pause_level, pause_fall;

    for (genvar i = 0; i < 4; i++) begin : g_push
        snake_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb (
            .clk(Clk), .rst(Rst), .i_raw(i_Push[i]),
            .o_level(push_level[i]), .o_fall(push_fall[i])
        );
    end

    snake_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_pause (
        .clk(Clk), .rst(Rst), .i_raw(i_Pause),
        .o_level(pause_level), .o_fall(pause_fall)
    );

    logic unused_deb;
    assign unused_deb = ^{push_level, pause_fall};

    state_e         state_q, state_d;
    dir_e           dir_q, dir_d, pend_q, pend_d, press_dir;
    logic [7:0]     score_q, score_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic           step_q, step_d;
    logic           after_step_q;
    logic           press_any;

    always_comb begin
        press_any = |push_fall;
        if      (push_fall[0]) press_dir = DIR_UP;
        else if (push_fall[1]) press_dir = DIR_DOWN;
        else if (push_fall[2]) press_dir = DIR_LEFT;
        else                   press_dir = DIR_RIGHT;
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        score_d = score_q;
        tick_d  = tick_q;
        step_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                if (press_any) begin
                    state_d = ST_PLAY;
                    dir_d   = press_dir;
                    pend_d  = press_dir;
                end
            end
            ST_PLAY: begin
                if (press_any && !is_reverse(press_dir, dir_q)) pend_d = press_dir;
                if (after_step_q && i_Collide) begin
                    state_d = ST_OVER;
                    tick_d  = '0;
                end else begin
                    if (after_step_q && i_Eat && score_q != SCORE_MAX) score_d = score_q + 8'd1;
                    // The tick is frozen on the cycle that enters PAUSE as well.
                    if (pause_level) begin
                        state_d = ST_PAUSE;
                    end else begin
                        tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
                        step_d = (tick_d == TICK_LAST);
                        if (step_d) dir_d = pend_d;
                    end
                end
            end
            ST_PAUSE: begin
                if (!pause_level) state_d = ST_PLAY;
            end
            ST_OVER: begin
                tick_d = '0;
                if (press_any) begin
                    state_d = ST_IDLE;
                    score_d = '0;
                    dir_d   = DIR_RIGHT;
                    pend_d  = DIR_RIGHT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_RIGHT;
            pend_q       <= DIR_RIGHT;
            score_q      <= '0;
            tick_q       <= '0;
            step_q       <= 1'b0;
            after_step_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            score_q      <= score_d;
            tick_q       <= tick_d;
            step_q       <= step_d;
            after_step_q <= step_q;
        end
    end

    assign o_Step  = step_q;
    assign o_Dir   = dir_q;
    assign o_State = state_q;
    assign o_Score = score_q;
endmodule

// File: tb/tb_snake_ctrl.sv
// Directed bench for snake_ctrl with TICK_DIV=8, DEB_CYCLES=4: a direction
// table plus hand sequences for start, pause, scoring, game over and reset.
module tb_snake_ctrl;
    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] i_Push;
    logic       i_Pause, i_Collide, i_Eat;
    logic       o_Step;
    logic [1:0] o_Dir, o_State;
    logic [7:0] o_Score;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    snake_ctrl #(.TICK_DIV(8), .DEB_CYCLES(4)) dut (
        .Clk(Clk), .Rst(Rst), .i_Push(i_Push), .i_Pause(i_Pause),
        .i_Collide(i_Collide), .i_Eat(i_Eat), .o_Step(o_Step),
        .o_Dir(o_Dir), .o_State(o_State), .o_Score(o_Score)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc_n++;

    typedef struct {
        logic [3:0] push;
        logic [1:0] exp_dir;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Hold a button pattern long enough to debounce, then release it.
    task automatic press(input logic [3:0] pat);
        i_Push = pat;
        cyc(6);
        i_Push = 4'hF;
        cyc(6);
    endtask

    task automatic wait_step(input string name);
        int n = 0;
        @(negedge Clk);
        while (!o_Step && n < 40) begin
            @(negedge Clk);
            n++;
        end
        if (!o_Step) begin
            checks++;
            errors++;
            $display("FAIL %s no step within budget", name);
        end
    endtask

    // Present datapath flags in the cycle that follows a step.
    task automatic after_step(input logic eat, input logic col);
        wait_step("after_step");
        @(negedge Clk);
        i_Eat = eat;
        i_Collide = col;
        @(negedge Clk);
        i_Eat = 1'b0;
        i_Collide = 1'b0;
    endtask

    initial begin
        int t0, t1, a, b, steps;
        tbl[0]  = '{4'b1110, 2'b01};
        tbl[1]  = '{4'b1011, 2'b10};
        tbl[2]  = '{4'b0111, 2'b10};
        tbl[3]  = '{4'b1110, 2'b00};
        tbl[4]  = '{4'b1110, 2'b00};
        tbl[5]  = '{4'b1101, 2'b00};
        tbl[6]  = '{4'b0111, 2'b11};
        tbl[7]  = '{4'b1010, 2'b00};
        tbl[8]  = '{4'b0101, 2'b00};
        tbl[9]  = '{4'b0011, 2'b10};
        tbl[10] = '{4'b0000, 2'b00};

        Rst = 1'b1; i_Push = 4'hF; i_Pause = 1'b0; i_Eat = 1'b0; i_Collide = 1'b0;
        cyc(3);
        chk("rst_state", o_State, 0);
        chk("rst_dir", o_Dir, 3);
        chk("rst_score", o_Score, 0);
        chk("rst_step", o_Step, 0);
        Rst = 1'b0;
        cyc(3);
        chk("idle_hold", o_State, 0);

        // Start on right and measure the step period.
        press(4'b0111);
        chk("start_state", o_State, 1);
        chk("start_dir", o_Dir, 3);
        wait_step("first_step");
        t0 = cyc_n;
        @(negedge Clk);
        chk("step_width", o_Step, 0);
        wait_step("second_step");
        t1 = cyc_n;
        chk("step_period1", t1 - t0, 8);
        wait_step("third_step");
        chk("step_period2", cyc_n - t1, 8);

        // Reverse turn is dropped; two presses before a step, last wins.
        press(4'b1011);
        wait_step("left_a");
        wait_step("left_b");
        chk("left_ignored", o_Dir, 3);
        wait_step("sync_ud");
        cyc(3);
        i_Push = 4'b1110;
        cyc(1);
        i_Push = 4'b1100;
        cyc(5);
        i_Push = 4'hF;
        wait_step("ud_step");
        chk("last_wins", o_Dir, 1);

        for (int i = 0; i < 11; i++) begin
            wait_step("tbl_sync");
            i_Push = tbl[i].push;
            cyc(5);
            i_Push = 4'hF;
            wait_step("tbl_a");
            wait_step("tbl_b");
            chk($sformatf("tbl_dir_%0d", i), o_Dir, tbl[i].exp_dir);
            chk($sformatf("tbl_state_%0d", i), o_State, 1);
        end

        // Pause: tick frozen, presses ignored, resume continues the count.
        // Entry and resume cycles each hold the tick, so PLAY cycles around
        // the pause add up to one more than the period.
        wait_step("pre_pause");
        i_Pause = 1'b1;
        a = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (o_State == 2'b10) break;
            a++;
        end
        chk("pause_entry_lag", a, 6);
        steps = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            if (k == 10) i_Push = 4'b1011;
            if (k == 18) i_Push = 4'hF;
            if (o_Step) steps++;
        end
        chk("pause_no_step", steps, 0);
        chk("pause_state", o_State, 2);
        i_Pause = 1'b0;
        b = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (o_State == 2'b01) b++;
            if (o_Step) break;
        end
        chk("resume_step_seen", o_Step, 1);
        chk("resume_remaining", a + b, 9);
        chk("pause_press_ignored", o_Dir, 0);

        // Flags outside the post-step cycle are ignored.
        wait_step("early_eat");
        i_Eat = 1'b1;
        i_Collide = 1'b1;
        @(negedge Clk);
        i_Eat = 1'b0;
        i_Collide = 1'b0;
        cyc(2);
        chk("early_eat_score", o_Score, 0);
        chk("early_col_state", o_State, 1);

        for (int k = 0; k < 3; k++) after_step(1'b1, 1'b0);
        chk("score_3", o_Score, 3);
        for (int k = 0; k < 252; k++) after_step(1'b1, 1'b0);
        chk("score_255", o_Score, 255);
        after_step(1'b1, 1'b0);
        chk("score_sat", o_Score, 255);

        after_step(1'b1, 1'b1);
        chk("over_state", o_State, 3);
        chk("over_score", o_Score, 255);
        steps = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (o_Step) steps++;
        end
        chk("over_no_step", steps, 0);
        press(4'b1101);
        chk("restart_state", o_State, 0);
        chk("restart_score", o_Score, 0);
        chk("restart_dir", o_Dir, 3);

        // Start on left: no reversal check on the starting press.
        press(4'b1011);
        chk("start_left_state", o_State, 1);
        chk("start_left_dir", o_Dir, 2);
        i_Push = 4'b1110;
        cyc(2);
        i_Push = 4'hF;
        wait_step("glitch_a");
        wait_step("glitch_b");
        chk("glitch_no_press", o_Dir, 2);
        after_step(1'b1, 1'b0);
        chk("pre_rst_score", o_Score, 1);

        wait_step("rst_on_step");
        Rst = 1'b1;
        #1;
        chk("mid_rst_step", o_Step, 0);
        chk("mid_rst_state", o_State, 0);
        chk("mid_rst_dir", o_Dir, 3);
        chk("mid_rst_score", o_Score, 0);
        cyc(3);
        Rst = 1'b0;
        steps = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            if (o_Step) steps++;
        end
        chk("post_rst_no_step", steps, 0);
        chk("post_rst_idle", o_State, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/snake_ctrl.md
SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000: clock cycles per snake move step, legal range >= 2.
REQ-002 SHALL have parameter DEB_CYCLES, default 16: stable cycles required to accept a button level, legal range >= 1.
REQ-003 SHALL have port Clk, input, 1 bit: single clock; all state rises on posedge.
REQ-004 SHALL have port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_Push, input, 4 bits: active-low buttons; bit0 up, bit1 down, bit2 left, bit3 right.
REQ-006 SHALL have port i_Pause, input, 1 bit: active-high pause level switch.
REQ-007 SHALL have port i_Collide, input, 1 bit: datapath flag that the head hit a wall or body, valid in the cycle after o_Step.
REQ-008 SHALL have port i_Eat, input, 1 bit: datapath flag that the head reached food, valid in the cycle after o_Step.
REQ-009 SHALL have port o_Step, output, 1 bit: one-cycle pulse that tells the datapath to advance the head.
REQ-010 SHALL have port o_Dir, output, 2 bits: applied direction; 00 up, 01 down, 10 left, 11 right.
REQ-011 SHALL have port o_State, output, 2 bits: 00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER.
REQ-012 SHALL have port o_Score, output, 8 bits: count of food eaten.

Function
REQ-013 SHALL pass each i_Push bit and i_Pause through a 2-FF synchronizer and then a debouncer; the debounced level changes only after DEB_CYCLES consecutive equal synchronized samples.
REQ-014 SHALL generate a one-cycle press event on each falling edge of a debounced i_Push bit.
REQ-015 SHALL resolve simultaneous press events by priority bit0 > bit1 > bit2 > bit3.
REQ-016 SHALL latch a press in PLAY as pending direction; a later press before the next o_Step overwrites it (last wins).
REQ-017 SHALL discard a press whose code is the reverse of the applied o_Dir (same bit1, different bit0); a press equal to o_Dir is accepted and has no effect.
REQ-018 SHALL copy the pending direction to o_Dir in the same cycle o_Step asserts, so the datapath sees the new o_Dir together with the step.
REQ-019 SHALL, in PLAY, count cycles 0..TICK_DIV-1 and assert o_Step in the cycle the count equals TICK_DIV-1, then wrap to 0.
REQ-020 SHALL hold the tick count unchanged in PAUSE, and SHALL clear it to 0 on the IDLE->PLAY transition.
REQ-021 State transitions:
- IDLE->PLAY on any press event; that press sets o_Dir directly, with no reversal check.
- PLAY->PAUSE when debounced pause = 1.
- PAUSE->PLAY when debounced pause = 0.
- PLAY->OVER when i_Collide = 1 in the cycle after o_Step.
- OVER->IDLE on any press event.
REQ-022 SHALL, in PLAY, increment o_Score when i_Eat = 1 in the cycle after o_Step, saturating at 255.
REQ-023 SHALL give collision priority when i_Collide and i_Eat are both 1: enter OVER and leave o_Score unchanged.
REQ-024 SHALL ignore i_Collide and i_Eat outside the cycle after o_Step, and in any state other than PLAY.
REQ-025 SHALL clear o_Score to 0, set o_Dir to 11, and clear the pending direction on the OVER->IDLE transition.
REQ-026 SHALL ignore press events in PAUSE; the pending direction is kept.
REQ-027 SHALL drive all outputs from registers.

Reset
REQ-028 SHALL, while Rst = 1, force asynchronously: state = IDLE, o_Step = 0, o_Dir = 11, pending direction = 11, o_Score = 0, tick count = 0, synchronizers and debouncers to the released level (push = 1, pause = 0).
REQ-029 SHALL, on Rst asserted mid-game, abandon the game with no o_Step pulse; after release, restart only from IDLE.

Structure
REQ-030 SHALL place state codes, direction codes and the reversal-check function in shared package snake_pkg.
REQ-031 SHALL use one sub-module, snake_debounce (synchronizer, debouncer, edge detect, parameter DEB_CYCLES), instantiated five times.

Verification (TICK_DIV = 8, DEB_CYCLES = 4)
REQ-032 SHALL cover start and step: after reset, press bit3 stable for 6+ cycles -> o_State = 01, o_Dir = 11, o_Step pulses exactly every 8 cycles.
REQ-033 SHALL cover direction changes: in PLAY with o_Dir = 11, press bit2 -> o_Dir stays 11; press bit0, then bit1 before the next step -> o_Dir = 01 at the next o_Step.
REQ-034 SHALL cover pause: raise i_Pause for 50 cycles -> o_State = 10 and no o_Step; release -> the first o_Step follows the remaining tick count, not a full 8 cycles.
REQ-035 SHALL cover scoring: i_Eat = 1 after each of 3 steps -> o_Score = 3; preload 255 plus one more eat -> o_Score stays 255.
REQ-036 SHALL cover game over: i_Collide and i_Eat both 1 after a step -> o_State = 11, o_Score unchanged; then any press -> o_State = 00, o_Score = 0, o_Dir = 11.
REQ-037 SHALL cover reset and glitches: assert Rst mid-PLAY -> all outputs immediately at reset values; a 2-cycle button glitch -> no press event.
